keypad_cursor_nav: RTL
======================

// Module: keypad_cursor_nav
// PURPOSE
//  Upstream front end of the calculator input path. Turns five raw board push-buttons
//  (up/down/left/right/center) into key selections for the downstream input-screen
//  processor: val[4:0] (selected key code) and enter_button (1-cycle press pulse).
//  Handles sync, debounce, press-edge detection and a wrapping cursor over a ROWS x COLS
//  key grid. Cursor position is also exported to the screen renderer for highlighting.
// PARAMETERS
//  DEBOUNCE_CYCLES  500_000  consecutive stable cycles needed to accept a level change (5 ms @ 100 MHz)
//  ROWS             4        key grid rows (1..4)
//  COLS             6        key grid columns (1..8); ROWS*COLS <= 32
// PORTS
//  clk           in   1  system clock; all logic on posedge
//  rst           in   1  synchronous, active-high reset
//  btn_up        in   1  raw asynchronous push-button, active-high
//  btn_down      in   1  raw asynchronous push-button, active-high
//  btn_left      in   1  raw asynchronous push-button, active-high
//  btn_right     in   1  raw asynchronous push-button, active-high
//  btn_center    in   1  raw asynchronous push-button, active-high (select/enter)
//  val           out  5  code of key under cursor = cursor_row*COLS + cursor_col
//  enter_button  out  1  single-cycle pulse per accepted center press
//  cursor_row    out  2  current cursor row, 0..ROWS-1
//  cursor_col    out  3  current cursor column, 0..COLS-1
// BEHAVIOUR
//  Reset: cursor_row=0, cursor_col=0, val=5'h00, enter_button=0; sync FFs, debounced
//   levels and counters all 0. Button held through reset = press after debounce.
//  Key map (default 4x6): codes 0x00-0x0F hex digits, 0x10-0x12/0x14/0x15 ALU ops,
//   0x13 EXE, 0x16/0x17 aux keys; code = row-major index.
//  Per button: 2-FF synchronizer -> debouncer -> rising-edge detector.
//  Debouncer: counter clears whenever sync level == debounced level; else increments;
//   on reaching DEBOUNCE_CYCLES debounced level flips, counter clears. Glitches shorter
//   than DEBOUNCE_CYCLES never flip it.
//  Press event = debounced 0->1, registered. Latency raw rise -> event/move/pulse:
//   exactly DEBOUNCE_CYCLES+3 clk edges. Release generates no event.
//  Cursor update on direction event (registered, same edge as event is consumed):
//   up: row = (row==0) ? ROWS-1 : row-1;   down: row = (row==ROWS-1) ? 0 : row+1
//   left: col = (col==0) ? COLS-1 : col-1; right: col = (col==COLS-1) ? 0 : col+1
//  val is registered from the next cursor value; val changes only on cursor moves.
//  enter_button: 1 cycle high, same edge as center event; val holds old key that cycle.
//  Holding a button: exactly one event, no auto-repeat.
//  Simultaneous events same cycle: center wins (enter issued, all moves dropped); else
//   one move by priority up > down > left > right, rest dropped (not queued).
//  Mid-operation reset: counters/levels/cursor return to reset values next edge; any
//   pending debounce discarded; no enter pulse in the cycle after rst deasserts.
//  Cursor never leaves 0..ROWS-1 / 0..COLS-1; val never exceeds ROWS*COLS-1.
// TESTING (DEBOUNCE_CYCLES=4, ROWS=4, COLS=6)
//  Reset, then btn_right high 20 cycles -> after 7 edges cursor (0,1), val=0x01, one move only.
//  btn_center high 3 cycles then low -> no enter_button, val unchanged (glitch rejected).
//  From (0,0): left, then up -> cursor (0,5) val=0x05, then (3,5) val=0x17 (wrap both axes).
//  Cursor at (3,1), center press -> enter_button high exactly 1 cycle, val=0x13 during pulse.
//  btn_up and btn_center rise same cycle -> one enter pulse, cursor unchanged;
//   btn_left+btn_right same cycle -> only left applied.
//  Hold btn_down, assert rst mid-debounce (cycle 2) -> cursor (0,0), no event; keep
//   holding after rst -> single move to (1,0) 7 edges after rst deasserts.

Source files
------------

// File: rtl/keypad_cursor_nav.sv
// Five-button front end: synchronize, debounce and edge-detect each button, then
// steer a wrapping cursor over a ROWS x COLS key grid and emit enter pulses.
module keypad_cursor_nav #(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int ROWS            = 4,
  parameter int COLS            = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_center,
  output logic [4:0] val,
  output logic       enter_button,
  output logic [1:0] cursor_row,
  output logic [2:0] cursor_col
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  // Bit order: 0 up, 1 down, 2 left, 3 right, 4 center.
  logic [4:0] btn;
  logic [4:0] press;

  assign btn = {btn_center, btn_right, btn_left, btn_down, btn_up};

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_btn
      logic          sync1_reg;
      logic          sync2_reg;
      logic          level_reg;
      logic          level_prev_reg;
      logic [CW-1:0] count_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_reg      <= 1'b0;
          sync2_reg      <= 1'b0;
          level_reg      <= 1'b0;
          level_prev_reg <= 1'b0;
          count_reg      <= '0;
        end else begin
          sync1_reg      <= btn[gi];
          sync2_reg      <= sync1_reg;
          level_prev_reg <= level_reg;
          // The edge that would make the count reach DEBOUNCE_CYCLES flips the level instead.
          if (sync2_reg == level_reg) begin
            count_reg <= '0;
          end else if (count_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
            level_reg <= ~level_reg;
            count_reg <= '0;
          end else begin
            count_reg <= count_reg + CW'(1);
          end
        end
      end

      assign press[gi] = level_reg & ~level_prev_reg;
    end
  endgenerate

  logic [1:0] row_reg, row_next;
  logic [2:0] col_reg, col_next;
  logic [4:0] val_reg, val_next;
  logic       enter_reg, enter_next;

  always_comb begin
    row_next   = row_reg;
    col_next   = col_reg;
    enter_next = 1'b0;
    // Center beats every direction; among directions only the highest priority moves.
    if (press[4]) begin
      enter_next = 1'b1;
    end else if (press[0]) begin
      row_next = (row_reg == 2'd0) ? 2'(ROWS - 1) : row_reg - 2'd1;
    end else if (press[1]) begin
      row_next = (row_reg == 2'(ROWS - 1)) ? 2'd0 : row_reg + 2'd1;
    end else if (press[2]) begin
      col_next = (col_reg == 3'd0) ? 3'(COLS - 1) : col_reg - 3'd1;
    end else if (press[3]) begin
      col_next = (col_reg == 3'(COLS - 1)) ? 3'd0 : col_reg + 3'd1;
    end
    val_next = 5'(int'(row_next) * COLS + int'(col_next));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_reg   <= 2'd0;
      col_reg   <= 3'd0;
      val_reg   <= 5'd0;
      enter_reg <= 1'b0;
    end else begin
      row_reg   <= row_next;
      col_reg   <= col_next;
      val_reg   <= val_next;
      enter_reg <= enter_next;
    end
  end

  assign cursor_row   = row_reg;
  assign cursor_col   = col_reg;
  assign val          = val_reg;
  assign enter_button = enter_reg;

endmodule
